pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised fetch-stage PC generator for the pipelined CPU.
- Holds the architectural PC register and resolves next-PC from decode-stage branch/jump information, with delay-slot semantics (targets relative to d_pc+4).
- Evaluates six branch conditions internally from rs/rt operand values.
- Handles fetch stall with a one-entry pending-redirect buffer, plus exception-vector and ERET redirects.

Parameters:
WIDTH, 32, address/data width; must be >= 32
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry address

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
stall  input  1  fetch hold (instruction memory not ready); decode keeps advancing
npc_op  input  3  000 seq, 001 branch, 010 j/jal imm26, 011 jr/jalr; others = seq
br_type  input  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez; others never taken
d_pc  input  WIDTH  PC of instruction in decode
imm  input  26  instr[25:0]; branch offset uses imm[15:0]
rs_val  input  WIDTH  forwarded GPR[rs]
rt_val  input  WIDTH  forwarded GPR[rt]
exc_req  input  1  take exception this cycle
eret_req  input  1  return from exception this cycle
epc  input  WIDTH  return address for ERET
pc  output  WIDTH  current fetch PC (registered)
pc_plus4  output  WIDTH  pc+4 (combinational)
link_addr  output  WIDTH  d_pc+8 (combinational, for jal/jalr)
redirect_taken  output  1  combinational: decode instruction redirects fetch
pend_valid  output  1  registered: pending redirect held
pc_misalign  output  1  registered: pc[1:0] != 0

Behaviour:
- Conditions: comparisons are signed two's complement. beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0.
- Targets:
  - branch: d_pc + 4 + (sext(imm[15:0]) << 2), modulo 2^WIDTH.
  - j: {d_pc_plus4[WIDTH-1:28], imm, 2'b00}.
  - jr: rs_val, unchanged; no alignment forcing.
- redirect_taken = (npc_op==001 && cond) || npc_op==010 || npc_op==011.
- redirect_target is the target selected for the active npc_op; it is internal and combinational.
- Register update priority at each rising edge, highest first:
  1. reset==0: pc<=RESET_PC, pend_valid<=0, pc_misalign<=0. Overrides all, including mid-stall with a pending redirect.
  2. exc_req: pc<=EXC_VEC, pend_valid<=0. Ignores stall.
  3. eret_req: pc<=epc, pend_valid<=0. Ignores stall.
  4. stall:
     - pc holds.
     - If redirect_taken && !pend_valid: capture pend_target<=redirect_target, pend_valid<=1.
     - If pend_valid already set: first capture wins; later redirects are ignored.
  5. !stall && pend_valid: pc<=pend_target, pend_valid<=0. A simultaneous redirect_taken is a protocol error; pending wins and the bench asserts.
  6. !stall && redirect_taken: pc<=redirect_target.
  7. Otherwise: pc<=pc+4 (wraps at 2^WIDTH).
- pc_misalign is loaded with ([1:0]!=0) of whatever value is loaded into pc. It holds while pc holds.
- exc_req && eret_req together: exception wins.
- Latency:
  - Redirect appears on pc one edge after redirect_taken with !stall.
  - Under stall, the redirect appears one edge after stall deasserts.
- Combinational outputs depend only on current inputs and pc. No combinational path from stall to pc.

Test Plan:
- Reset: hold reset=0 for 2 edges with stall=0 → pc=0x3000, pend_valid=0, pc_misalign=0. Release → pc 0x3004, 0x3008.
- Branch taken/not: d_pc=0x3010, npc_op=001, br_type=000, rs=rt=5, imm=0xFFFE → pc=0x300C. Same with rt=6 → pc=old pc+4. bgtz with rs=0x80000000 → not taken.
- Jumps: d_pc=0x3020, npc_op=010, imm=0x0000C10 → pc=0x3040, link_addr=0x3028. npc_op=011, rs_val=0x3102 → pc=0x3102, pc_misalign=1.
- Stall capture: stall=1 at pc=0x3008 while jr rs_val=0x3200, then redirect drops; stall=1 for 3 cycles → pc holds 0x3008, pend_valid=1. Stall drops → pc=0x3200, pend_valid=0, next 0x3204.
- Exception/ERET: exc_req=1 during stall with pend_valid=1 → pc=0x4180, pend_valid=0. eret_req=1, epc=0x3050 → pc=0x3050. Both together → pc=0x4180.
- Reset mid-operation: reset=0 while pend_valid=1 and pc=0x3200 → pc=0x3000, pend_valid=0 on that edge.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter generator.
// Holds the fetch PC and resolves the next PC from decode-stage branch and
// jump information. Targets are relative to d_pc+4 because of the delay slot.
// Redirects that arrive while fetch is stalled are held in a one-entry buffer.
// Exception entry and ERET redirects override the stall.
// Ports:
//   clk, reset                 clock and synchronous active-low reset
//   stall                      fetch hold; decode keeps advancing
//   npc_op, br_type            next-PC operation and branch condition select
//   d_pc, imm                  decode PC and instr[25:0]
//   rs_val, rt_val             forwarded operands for conditions / jr
//   exc_req, eret_req, epc     exception entry and return controls
//   pc, pend_valid, pc_misalign  registered state
//   pc_plus4, link_addr, redirect_taken  combinational helpers
// WIDTH must be >= 32.
module pc_gen #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VEC  = WIDTH'(32'h0000_4180)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       npc_op,
   input  logic [2:0]       br_type,
   input  logic [WIDTH-1:0] d_pc,
   input  logic [25:0]      imm,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] link_addr,
   output logic             redirect_taken,
   output logic             pend_valid,
   output logic             pc_misalign
);

   localparam logic [2:0] OP_BRANCH = 3'b001;
   localparam logic [2:0] OP_JUMP   = 3'b010;
   localparam logic [2:0] OP_JR     = 3'b011;

   localparam logic [2:0] BR_BEQ  = 3'b000;
   localparam logic [2:0] BR_BNE  = 3'b001;
   localparam logic [2:0] BR_BLEZ = 3'b010;
   localparam logic [2:0] BR_BGTZ = 3'b011;
   localparam logic [2:0] BR_BLTZ = 3'b100;
   localparam logic [2:0] BR_BGEZ = 3'b101;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_target_q, pend_target_d;
   logic             pend_valid_q, pend_valid_d;
   logic             pc_misalign_q, pc_misalign_d;

   logic [WIDTH-1:0] d_pc_plus4;
   logic [WIDTH-1:0] br_offset;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_target;
   logic [WIDTH-1:0] redirect_target;
   logic             br_cond;
   logic             rs_zero;
   logic             rs_neg;

   // Address arithmetic shared by branch, jump and link
   assign d_pc_plus4 = d_pc + WIDTH'(4);
   assign br_offset  = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
   assign br_target  = d_pc_plus4 + br_offset;
   assign j_target   = {d_pc_plus4[WIDTH-1:28], imm, 2'b00};
   assign pc_plus4   = pc_q + WIDTH'(4);
   assign link_addr  = d_pc + WIDTH'(8);

   // Signed compare-against-zero reduces to sign bit and zero detect
   assign rs_zero = (rs_val == '0);
   assign rs_neg  = rs_val[WIDTH-1];

   // Branch condition evaluation
   always_comb begin
      br_cond = 1'b0;
      case (br_type)
         BR_BEQ:  br_cond = (rs_val == rt_val);
         BR_BNE:  br_cond = (rs_val != rt_val);
         BR_BLEZ: br_cond = rs_neg | rs_zero;
         BR_BGTZ: br_cond = ~rs_neg & ~rs_zero;
         BR_BLTZ: br_cond = rs_neg;
         BR_BGEZ: br_cond = ~rs_neg;
         default: br_cond = 1'b0;
      endcase
   end

   // Redirect decision and target select
   always_comb begin
      redirect_taken  = 1'b0;
      redirect_target = pc_plus4;
      case (npc_op)
         OP_BRANCH: begin
            redirect_taken  = br_cond;
            redirect_target = br_target;
         end
         OP_JUMP: begin
            redirect_taken  = 1'b1;
            redirect_target = j_target;
         end
         OP_JR: begin
            redirect_taken  = 1'b1;
            redirect_target = rs_val;
         end
         default: begin
            redirect_taken  = 1'b0;
            redirect_target = pc_plus4;
         end
      endcase
   end

   // Next-state priority: exception, eret, stall, pending, redirect, sequential
   always_comb begin
      pc_d          = pc_plus4;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (exc_req) begin
         pc_d         = EXC_VEC;
         pend_valid_d = 1'b0;
      end else if (eret_req) begin
         pc_d         = epc;
         pend_valid_d = 1'b0;
      end else if (stall) begin
         pc_d = pc_q;
         // First redirect captured during a stall wins
         if (redirect_taken && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
         end
      end else if (pend_valid_q) begin
         pc_d         = pend_target_q;
         pend_valid_d = 1'b0;
      end else if (redirect_taken) begin
         pc_d = redirect_target;
      end
      pc_misalign_d = (pc_d[1:0] != 2'b00);
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q          <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         pc_misalign_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         pc_misalign_q <= pc_misalign_d;
      end
   end

   assign pc          = pc_q;
   assign pend_valid  = pend_valid_q;
   assign pc_misalign = pc_misalign_q;

endmodule
